spram_lsearch: RTL and testbench
================================

// Module: spram_lsearch
// PURPOSE
//  Parametrised single-port RAM with a built-in linear-search engine.
//  Normal port: synchronous write, registered-address read (1-cycle read latency).
//  Search engine: scans addresses 0..len one word per cycle and reports the lowest
//  address holding key. Used as a lookup table where software must locate a value.
// PARAMETERS
//  A  8    address width
//  D  8    data width (memory word width is D; independent of A)
//  R  256  depth, must equal 2**A
// PORTS
//  clk         in   1  clock, all state updates on rising edge
//  rst_n       in   1  reset, synchronous, active-low
//  ce          in   1  access enable for normal port
//  we          in   1  write enable (qualified by ce)
//  addr        in   A  normal-port address
//  data        in   D  write data
//  q           out  D  read data = mem[r_addr]
//  start       in   1  search request, sampled only in IDLE
//  key         in   D  search value, captured with start
//  len         in   A  last address to scan (inclusive), captured with start
//  busy        out  1  high while state != IDLE
//  done        out  1  one-cycle pulse when search finishes
//  found       out  1  search result valid-hit flag, held until next start
//  found_addr  out  A  lowest matching address, held until next start
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, r_addr=0, idx=0, busy=0, done=0, found=0,
//   found_addr=0. Memory contents NOT cleared and preserved across reset.
//  Normal port (IDLE only): ce&we -> mem[addr]<=data; ce -> r_addr<=addr.
//   q is combinational from mem[r_addr]: read returns data 1 cycle after addr;
//   write+read same addr same cycle -> q shows the new data next cycle.
//   ce=0 -> r_addr holds, q holds (unless mem[r_addr] written earlier).
//  FSM states: IDLE, SCAN, DONE.
//   IDLE: start=1 -> key_r<=key, len_r<=len, idx<=0, found<=0, found_addr<=0, go SCAN.
//         start and ce same cycle -> normal-port access is performed, search starts.
//   SCAN: compare mem[idx]==key_r combinationally each cycle.
//         hit -> found<=1, found_addr<=idx, go DONE.
//         miss & idx==len_r -> found<=0, go DONE.
//         miss otherwise -> idx<=idx+1.
//         ce/we/addr ignored: no writes, r_addr frozen, q held.
//   DONE: done=1 for exactly this cycle; go IDLE. start here is ignored.
//  busy=1 in SCAN and DONE; start while busy is dropped (not queued).
//  Timing: start sampled at edge E0; hit at address k -> done high in cycle after
//   edge E(k+1), i.e. k+2 cycles after start cycle. Miss -> done after len+2 cycles.
//  First match wins (lowest address). len=0 scans address 0 only.
//   len=R-1 scans full array; idx never wraps (terminates at len_r).
//  Reset mid-search: aborts immediately, done not pulsed, results cleared to 0.
//  found/found_addr stable from DONE until the next accepted start.
// TESTING
//  1 Write mem[i]=i^8'hA5 for i=0..255, read back -> q==i^8'hA5 one cycle after addr.
//  2 Same-cycle write 8'h3C + read at addr 7 -> q==8'h3C next cycle.
//  3 mem[0]=8'h11, search key=8'h11 len=255 -> done 2 cycles after start, found=1,
//    found_addr=0.
//  4 mem[10]=mem[20]=8'h77, key=8'h77 -> found=1, found_addr=10, done at cycle 12.
//  5 key absent, len=255 -> done 257 cycles after start, found=0, found_addr=0.
//    Same key with len=9 while match at 10 -> miss, done at cycle 11.
//  6 During SCAN: ce=1 we=1 addr=5 data=8'hFF and a second start -> mem[5] unchanged,
//    second start dropped; rst_n=0 mid-SCAN -> busy=0, done never pulses, found=0,
//    memory contents intact on readback.

Source files
------------

// File: rtl/spram_lsearch.sv
// Single-port RAM with a registered-address read port and a linear-search engine.
// The engine scans addresses 0..len and reports the lowest one that holds key.
module spram_lsearch #(
    parameter int A = 8,
    parameter int D = 8,
    parameter int R = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         we,
    input  logic [A-1:0] addr,
    input  logic [D-1:0] data,
    output logic [D-1:0] q,
    input  logic         start,
    input  logic [D-1:0] key,
    input  logic [A-1:0] len,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [A-1:0] found_addr
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t       state_q;
    logic [D-1:0] mem [R];
    logic [A-1:0] r_addr_q, idx_q, len_q, found_addr_q;
    logic [D-1:0] key_q;
    logic         busy_q, done_q, found_q;
    logic         idle, hit, last;
    logic [A-1:0] idx_d;

    assign idle  = (state_q == IDLE);
    assign hit   = (mem[idx_q] == key_q);
    assign last  = (idx_q == len_q);
    assign idx_d = idx_q + A'(1);

    // Memory has no reset so contents survive rst_n; the port is locked out while searching.
    always_ff @(posedge clk) begin
        if (idle && ce && we)
            mem[addr] <= data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            r_addr_q     <= '0;
            idx_q        <= '0;
            key_q        <= '0;
            len_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            found_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ce)
                        r_addr_q <= addr;
                    if (start) begin
                        key_q        <= key;
                        len_q        <= len;
                        idx_q        <= '0;
                        found_q      <= 1'b0;
                        found_addr_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= SCAN;
                    end
                end
                SCAN: begin
                    // Stop at len_q rather than wrapping so len = R-1 covers the array once.
                    if (hit) begin
                        found_q      <= 1'b1;
                        found_addr_q <= idx_q;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end else if (last) begin
                        found_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign q          = mem[r_addr_q];
    assign busy       = busy_q;
    assign done       = done_q;
    assign found      = found_q;
    assign found_addr = found_addr_q;

endmodule

// File: tb/tb_spram_lsearch.sv
// Directed bench for spram_lsearch: stimulus pushes expected read data and search
// results into queues; a forked monitor pops them when q is due or done pulses.
module tb_spram_lsearch;

    logic       clk = 1'b0;
    logic       rst_n, ce, we, start;
    logic [7:0] addr, data, key, len;
    logic [7:0] q, found_addr;
    logic       busy, done, found;

    spram_lsearch #(.A(8), .D(8), .R(256)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .we(we), .addr(addr), .data(data), .q(q),
        .start(start), .key(key), .len(len), .busy(busy), .done(done),
        .found(found), .found_addr(found_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f;
        logic [7:0]  a;
        int unsigned c;
    } sexp_t;

    logic [7:0]  rd_exp[$];
    sexp_t       sq[$];
    logic [7:0]  shadow [256];
    int unsigned cyc = 0;
    logic        rd_req = 1'b0;
    logic        rd_chk = 1'b0;
    int          vecs = 0;
    int          errs = 0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_chk <= rd_req;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic w, input logic [7:0] a, input logic [7:0] d, input bit c);
        ce = 1'b1; we = w; addr = a; data = d;
        if (w) shadow[a] = d;
        if (c) begin
            rd_exp.push_back(shadow[a]);
            rd_req = 1'b1;
        end
        tick(1);
        ce = 1'b0; we = 1'b0; rd_req = 1'b0;
    endtask

    task automatic srch(input logic [7:0] k, input logic [7:0] l, input logic f,
                        input logic [7:0] a, input int unsigned lat);
        sexp_t s;
        s.f = f; s.a = a; s.c = cyc + lat;
        sq.push_back(s);
        start = 1'b1; key = k; len = l;
        tick(1);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sq.size() != 0; i++) @(posedge clk);
        #1;
        if (sq.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL search timeout: got no done, expected done within 400 cycles");
            sq.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; we = 1'b0; start = 1'b0;
        addr = '0; data = '0; key = '0; len = '0;
        fork
            forever begin
                @(negedge clk);
                if (rd_chk && rd_exp.size() != 0) chk("read q", q, rd_exp.pop_front());
                if (done) begin
                    if (sq.size() == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL unexpected done: got done=1 expected done=0");
                    end else begin
                        sexp_t s;
                        s = sq.pop_front();
                        chk("found", found, s.f);
                        chk("found_addr", found_addr, s.a);
                        chk("done cycle", cyc, s.c);
                    end
                end
            end
        join_none

        tick(2);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset found", found, 0);
        chk("reset found_addr", found_addr, 0);
        rst_n = 1'b1;
        tick(1);

        // Fill and read back
        for (int i = 0; i < 256; i++) acc(1'b1, 8'(i), 8'(i) ^ 8'hA5, 1'b0);
        for (int i = 0; i < 256; i++) acc(1'b0, 8'(i), 8'h00, 1'b1);
        // Write and read same address, same cycle
        acc(1'b1, 8'd7, 8'h3C, 1'b1);

        // Hit at address 0, plus len=0 hit and miss
        acc(1'b1, 8'd0, 8'h11, 1'b0);
        srch(8'h11, 8'd255, 1'b1, 8'd0, 2);  drain();
        srch(8'h11, 8'd0,   1'b1, 8'd0, 2);  drain();
        srch(8'h77, 8'd0,   1'b0, 8'd0, 2);  drain();

        // First of two matches wins; result held after done
        acc(1'b1, 8'd10, 8'h77, 1'b0);
        acc(1'b1, 8'd20, 8'h77, 1'b0);
        srch(8'h77, 8'd255, 1'b1, 8'd10, 12); drain();
        tick(3);
        chk("held found", found, 1);
        chk("held found_addr", found_addr, 10);

        // Full-array miss, then miss because the match lies past len
        srch(8'hA5, 8'd255, 1'b0, 8'd0, 257); drain();
        srch(8'h77, 8'd9,   1'b0, 8'd0, 11);  drain();

        // Port access and second start during SCAN are ignored; q holds old r_addr data
        acc(1'b0, 8'd3, 8'h00, 1'b1);
        srch(8'hA5, 8'd255, 1'b0, 8'd0, 257);
        tick(3);
        chk("busy in scan", busy, 1);
        ce = 1'b1; we = 1'b1; addr = 8'd5; data = 8'hFF;
        start = 1'b1; key = 8'h11; len = 8'd0;
        rd_exp.push_back(shadow[3]);
        rd_req = 1'b1;
        tick(1);
        ce = 1'b0; we = 1'b0; start = 1'b0; rd_req = 1'b0;
        drain();
        acc(1'b0, 8'd5, 8'h00, 1'b1);

        // Reset mid-scan: abort, no done, results cleared, memory kept
        srch(8'h77, 8'd255, 1'b1, 8'd10, 12); drain();
        start = 1'b1; key = 8'hA5; len = 8'd255;
        tick(1);
        start = 1'b0;
        tick(20);
        chk("busy before reset", busy, 1);
        rst_n = 1'b0;
        tick(1);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort found", found, 0);
        chk("abort found_addr", found_addr, 0);
        rst_n = 1'b1;
        tick(300);
        acc(1'b0, 8'd0,   8'h00, 1'b1);
        acc(1'b0, 8'd7,   8'h00, 1'b1);
        acc(1'b0, 8'd10,  8'h00, 1'b1);
        acc(1'b0, 8'd100, 8'h00, 1'b1);
        acc(1'b0, 8'd255, 8'h00, 1'b1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
